// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module sync_fifo #(
    parameter int g_width  = 8,
    parameter int g_depth  = 6,
    parameter int g_fwft   = 0,
    parameter int g_afull  = 2**g_depth - 2,
    parameter int g_aempty = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wren,
    input  logic [g_width-1:0] i_dataW,
    input  logic               i_ren,
    output logic [g_width-1:0] o_dataR,
    output logic               o_empty,
    output logic               o_full,
    output logic [g_depth:0]   o_count,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int               c_entries = 2**g_depth;
    localparam logic [g_depth:0] c_full    = (g_depth+1)'(c_entries);
    localparam logic [g_depth:0] c_afull   = (g_depth+1)'(g_afull);
    localparam logic [g_depth:0] c_aempty  = (g_depth+1)'(g_aempty);
    localparam logic [g_depth:0] c_one     = (g_depth+1)'(1);
    localparam logic [g_depth-1:0] c_ptr_one = (g_depth)'(1);

    logic [g_width-1:0] mem [c_entries];
    logic [g_depth-1:0] wr_ptr;
    logic [g_depth-1:0] rd_ptr;
    logic [g_depth:0]   count_next;
    logic [g_depth:0]   mem_level;
    logic               wr_acc;
    logic               rd_acc;
    logic               mem_pop;
    logic               valid_q;
    logic               valid_next;
    logic               empty_next;

    always_comb begin
        wr_acc     = i_wren && !o_full;
        rd_acc     = i_ren && !o_empty;
        count_next = o_count;
        if (wr_acc && !rd_acc) begin
            count_next = o_count + c_one;
        end else if (!wr_acc && rd_acc) begin
            count_next = o_count - c_one;
        end
        // Words still in memory, i.e. not yet moved into the FWFT output register.
        mem_level = o_count - {{g_depth{1'b0}}, valid_q};
        if (g_fwft != 0) begin
            mem_pop    = (mem_level != '0) && (!valid_q || rd_acc);
            valid_next = mem_pop || (valid_q && !rd_acc);
            empty_next = !valid_next;
        end else begin
            mem_pop    = rd_acc;
            valid_next = 1'b0;
            empty_next = (count_next == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[wr_ptr] <= i_dataW;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            valid_q        <= 1'b0;
            o_dataR        <= '0;
            o_count        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + c_ptr_one;
            end
            if (mem_pop) begin
                rd_ptr  <= rd_ptr + c_ptr_one;
                o_dataR <= mem[rd_ptr];
            end
            valid_q        <= valid_next;
            o_count        <= count_next;
            o_empty        <= empty_next;
            o_full         <= (count_next == c_full);
            o_almost_full  <= (count_next >= c_afull);
            o_almost_empty <= (count_next <= c_aempty);
            o_overflow     <= i_wren && o_full;
            o_underflow    <= i_ren && o_empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT depth-4 instances plus a depth-8 threshold
// instance, all driven by the same stimulus and checked against queue-based models.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wren;
    logic [7:0] dataW;
    logic       ren;

    logic [7:0] s_dataR, f_dataR, t_dataR;
    logic       s_empty, f_empty, t_empty;
    logic       s_full, f_full, t_full;
    logic [2:0] s_count, f_count;
    logic [3:0] t_count;
    logic       s_af, f_af, t_af;
    logic       s_ae, f_ae, t_ae;
    logic       s_ovf, f_ovf, t_ovf;
    logic       s_unf, f_unf, t_unf;

    int total = 0;
    int bad   = 0;

    byte unsigned s_q[$];
    byte unsigned f_q[$];
    int           t_cnt;
    byte unsigned s_dr;
    bit           f_pres;
    bit           was_rst;
    bit e_s_ovf, e_s_unf, e_f_ovf, e_f_unf, e_t_ovf, e_t_unf;

    sync_fifo #(.g_width(8), .g_depth(2), .g_fwft(0)) u_std (
        .i_clk(clk), .i_rst(rst), .i_wren(wren), .i_dataW(dataW), .i_ren(ren),
        .o_dataR(s_dataR), .o_empty(s_empty), .o_full(s_full), .o_count(s_count),
        .o_almost_full(s_af), .o_almost_empty(s_ae),
        .o_overflow(s_ovf), .o_underflow(s_unf));

    sync_fifo #(.g_width(8), .g_depth(2), .g_fwft(1)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_wren(wren), .i_dataW(dataW), .i_ren(ren),
        .o_dataR(f_dataR), .o_empty(f_empty), .o_full(f_full), .o_count(f_count),
        .o_almost_full(f_af), .o_almost_empty(f_ae),
        .o_overflow(f_ovf), .o_underflow(f_unf));

    sync_fifo #(.g_width(8), .g_depth(3), .g_fwft(0), .g_afull(6), .g_aempty(1)) u_thr (
        .i_clk(clk), .i_rst(rst), .i_wren(wren), .i_dataW(dataW), .i_ren(ren),
        .o_dataR(t_dataR), .o_empty(t_empty), .o_full(t_full), .o_count(t_count),
        .o_almost_full(t_af), .o_almost_empty(t_ae),
        .o_overflow(t_ovf), .o_underflow(t_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the models at the edge, check all outputs after it.
    task automatic step(input bit w, input byte unsigned d, input bit r);
        int s_n, f_n, t_n, f_stored;
        wren  = w;
        dataW = d;
        ren   = r;
        if (!rst && f_pres) chk("f_head", 32'(f_dataR), 32'(f_q[0]));
        s_n = s_q.size();
        f_n = f_q.size();
        t_n = t_cnt;
        @(posedge clk);
        was_rst = rst;
        if (rst) begin
            s_q.delete();
            f_q.delete();
            t_cnt  = 0;
            s_dr   = 8'h00;
            f_pres = 1'b0;
            {e_s_ovf, e_s_unf, e_f_ovf, e_f_unf, e_t_ovf, e_t_unf} = '0;
        end else begin
            e_s_ovf = w && (s_n == 4);
            e_s_unf = r && (s_n == 0);
            if (r && s_n > 0) s_dr = s_q.pop_front();
            if (w && s_n < 4) s_q.push_back(d);

            e_f_ovf  = w && (f_n == 4);
            e_f_unf  = r && !f_pres;
            f_stored = f_n - (f_pres ? 1 : 0);
            if (r && f_pres) begin
                void'(f_q.pop_front());
                f_pres = (f_stored > 0);
            end else if (!f_pres && f_stored > 0) begin
                f_pres = 1'b1;
            end
            if (w && f_n < 4) f_q.push_back(d);

            e_t_ovf = w && (t_n == 8);
            e_t_unf = r && (t_n == 0);
            if (w && t_n < 8) t_cnt++;
            if (r && t_n > 0) t_cnt--;
        end
        #1;
        chk("s_count", 32'(s_count), s_q.size());
        chk("s_full",  32'(s_full),  32'(s_q.size() == 4));
        chk("s_empty", 32'(s_empty), 32'(s_q.size() == 0));
        chk("s_dataR", 32'(s_dataR), 32'(s_dr));
        chk("s_ovf",   32'(s_ovf),   32'(e_s_ovf));
        chk("s_unf",   32'(s_unf),   32'(e_s_unf));
        chk("s_afull", 32'(s_af),    32'(s_q.size() >= 2));
        chk("s_aempty",32'(s_ae),    32'(s_q.size() <= 2));
        chk("f_count", 32'(f_count), f_q.size());
        chk("f_empty", 32'(f_empty), 32'(!f_pres));
        chk("f_full",  32'(f_full),  32'(f_q.size() == 4));
        chk("f_ovf",   32'(f_ovf),   32'(e_f_ovf));
        chk("f_unf",   32'(f_unf),   32'(e_f_unf));
        if (was_rst) chk("f_dataR_rst", 32'(f_dataR), 32'h0);
        chk("t_count", 32'(t_count), t_cnt);
        chk("t_full",  32'(t_full),  32'(t_cnt == 8));
        chk("t_empty", 32'(t_empty), 32'(t_cnt == 0));
        chk("t_afull", 32'(t_af),    32'(t_cnt >= 6));
        chk("t_aempty",32'(t_ae),    32'(t_cnt <= 1));
        chk("t_ovf",   32'(t_ovf),   32'(e_t_ovf));
        chk("t_unf",   32'(t_unf),   32'(e_t_unf));
    endtask

    initial begin
        t_cnt  = 0;
        s_dr   = 8'h00;
        f_pres = 1'b0;
        rst    = 1'b1;
        wren   = 1'b0;
        ren    = 1'b0;
        dataW  = 8'h00;

        // reset with requests asserted: they must be ignored
        step(1'b1, 8'hEE, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // underflow from empty
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // fill to full, then one rejected write
        for (int i = 0; i < 4; i++) step(1'b1, 8'((i + 1) * 8'h11), 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // simultaneous at full, then at count 2, then drain past empty
        step(1'b1, 8'h66, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // FWFT first-word latency
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // thresholds: fill the depth-8 instance past full, then drain
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

        // streaming with random simultaneous reads
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 1), 1'($urandom_range(1, 0)));
        repeat (12) step(1'b0, 8'h00, 1'b1);

        // reset mid-operation, then a fresh word goes through
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
        rst = 1'b1;
        step(1'b1, 8'h99, 1'b0);
        rst = 1'b0;
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
